// File: rtl/clock_divider_bank_pkg.sv
// Shared defaults and helpers for the clock divider bank.
// Holds the channel/count sizing and the per-channel reset half-period rule.
package clkdiv_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int CH_W       = 4;

  // Channel i starts at 2^i, clamped to the largest power of two the counter can hold.
  function automatic int unsigned reset_half(int unsigned ch, int unsigned cnt_w);
    if (ch >= cnt_w - 1) return 32'd1 << (cnt_w - 1);
    return 32'd1 << ch;
  endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Configuration request channel: valid/ready handshake carrying a channel index and half-period.
// The master presents a request; the bank accepts it on any cycle where both valid and ready are high.
interface clock_divider_bank_if import clkdiv_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;

  modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);

endinterface

// File: rtl/clock_divider_bank_channel.sv
// One divided-clock channel: half-period counter, toggle, registered rising-edge tick.
// A pending half-period is taken only on the falling toggle (or an align), so no pulse is ever cut short.
module clkdiv_channel import clkdiv_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             align_i,
  input  logic             upd_vld_i,
  input  logic [CNT_W-1:0] upd_half_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             applied_o
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(reset_half(CH, CNT_W));
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    wrap      = (cnt_q == h_q - ONE);
    h_d       = h_q;
    cnt_d     = wrap ? '0 : cnt_q + ONE;
    clk_d     = wrap ? ~clk_q : clk_q;
    tick_d    = wrap & ~clk_q;
    applied_o = upd_vld_i & ((wrap & clk_q) | align_i);
    if (applied_o) h_d = upd_half_i;
    // Align restarts every channel from the low phase with no tick.
    if (align_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= RST_HALF;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH divided clocks reprogrammed through a single pending slot; optional align input under CLKDIV_ALIGN_EN.
// cfg_ready is low while a request waits for its channel's falling edge; out-of-range channels are accepted and dropped.
module clock_divider_bank import clkdiv_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
`ifdef CLKDIV_ALIGN_EN
  input  logic              align_req,
`endif
  clock_divider_bank_if.slave cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic             pend_vld_q, pend_vld_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic [NUM_CH-1:0] applied;
  logic             align_w;
  logic             ch_ok;

`ifdef CLKDIV_ALIGN_EN
  assign align_w = align_req;
`else
  assign align_w = 1'b0;
`endif

  assign cfg.cfg_ready = ~pend_vld_q;
  assign ch_ok         = (int'(cfg.cfg_ch) < NUM_CH);

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_ch_d   = pend_ch_q;
    pend_half_d = pend_half_q;
    if (|applied) pend_vld_d = 1'b0;
    if (cfg.cfg_valid && !pend_vld_q && ch_ok) begin
      pend_vld_d  = 1'b1;
      pend_ch_d   = cfg.cfg_ch;
      pend_half_d = (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld_q  <= 1'b0;
      pend_ch_q   <= '0;
      pend_half_q <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_ch_q   <= pend_ch_d;
      pend_half_q <= pend_half_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .CNT_W (CNT_W),
      .CH    (i)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .align_i    (align_w),
      .upd_vld_i  (pend_vld_q && (pend_ch_q == CH_W'(i))),
      .upd_half_i (pend_half_q),
      .clk_o      (clk_out[i]),
      .tick_o     (tick[i]),
      .applied_o  (applied[i])
    );
  end

endmodule
